booth_mul8: RTL

- Sequential radix-2 Booth multiplier for the 8-bit ALU.
- It is the multiply counterpart of the SRT divider and shares its start/done handshake style.
- It computes the signed 8x8 -> 16-bit product over a fixed number of cycles, using one 9-bit add/sub datapath (select=1 subtracts).
- Outputs are the registered product plus zero/negative flags for the ALU flag mux.

---
 rtl/booth_mul8_if.sv | 23 ++
 rtl/booth_mul8.sv | 126 ++++++++++++
 2 files changed

// File: rtl/booth_mul8_if.sv
// Start/done handshake bundle for the Booth multiplier: operands in, product and ALU flags out.
interface booth_mul8_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   done;
  logic                   busy;
  logic                   zero;
  logic                   negative;

  modport master (
    output start, multiplicand, multiplier,
    input  product, done, busy, zero, negative
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, done, busy, zero, negative
  );
endinterface

// File: rtl/booth_mul8.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product in a fixed
// 2*ITER+1 cycles, with registered zero/negative flags for the ALU flag mux.
module booth_mul8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITER  = WIDTH
) (
  input logic        clk,
  input logic        rst,
  booth_mul8_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StEval  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  // A and M carry one extra bit so that A - M with M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [3:0]         count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;

  logic               sub;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  // Single add/sub datapath: pair 10 subtracts (A + ~M + 1), pair 01 adds.
  assign sub    = q_q[0];
  assign addend = sub ? ~m_q : m_q;
  assign sum    = a_q + addend + {{WIDTH{1'b0}}, sub};
  assign result = {a_q[WIDTH-1:0], q_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    m_d        = m_q;
    q_d        = q_q;
    q1_d       = q1_q;
    count_d    = count_q;
    product_d  = product_q;
    done_d     = done_q;
    busy_d     = busy_q;
    zero_d     = zero_q;
    negative_d = negative_q;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = StEval;
        end
      end
      StEval: begin
        if (q_q[0] ^ q1_q) begin
          a_d = sum;
        end
        state_d = StShift;
      end
      StShift: begin
        a_d     = {a_q[WIDTH], a_q[WIDTH:1]};
        q_d     = {a_q[0], q_q[WIDTH-1:1]};
        q1_d    = q_q[0];
        count_d = count_q + 4'd1;
        state_d = (count_q == 4'(ITER - 1)) ? StDone : StEval;
      end
      StDone: begin
        product_d  = result;
        zero_d     = (result == '0);
        negative_d = a_q[WIDTH-1];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      m_q        <= '0;
      q_q        <= '0;
      q1_q       <= 1'b0;
      count_q    <= '0;
      product_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      m_q        <= m_d;
      q_q        <= q_d;
      q1_q       <= q1_d;
      count_q    <= count_d;
      product_q  <= product_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign bus.product  = product_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;

endmodule
